led_frame_sequencer: RTL and testbench
======================================

# led_frame_sequencer

Frame-level controller between the per-zone brightness calculator and the MiniLED driver, running on the recovered LVDS pixel clock. It watches vertical sync and gates and clears the 360-zone accumulators. Once per frame it copies the zone results into a shadow buffer, one zone per cycle, and hands that buffer to the driver with a req/ack handshake. When video disappears it substitutes a fixed fallback brightness.

## Interface
Parameters:
- `ZONES`, 360: number of dimming zones.
- `DW`, 8: bits per zone.
- `TIMEOUT_CYC`, 2_000_000: cycles without a vsync rising edge before video is declared lost.
- `FALLBACK`, 8'h40: zone value used while video is lost.

Ports:
- `I_clk`, in, 1: pixel clock. Only clock.
- `I_rst_n`, in, 1: reset, synchronous, active-low.
- `I_vs`, in, 1: vertical sync, active-high, synchronous to `I_clk`.
- `I_zone_data`, in, ZONES*DW: flattened accumulator results. Zone k is `[k*DW +: DW]`.
- `O_acc_en`, out, 1: accumulation enable to the calculator.
- `O_acc_clr`, out, 1: one-cycle accumulator clear pulse.
- `O_zone_data`, out, ZONES*DW: shadow buffer presented to the driver.
- `O_upd_req`, out, 1: shadow buffer valid and stable.
- `I_upd_ack`, in, 1: driver has latched `O_zone_data`.
- `O_video_lost`, out, 1: sticky loss flag.
- `O_drop`, out, 1: one-cycle pulse when a frame is skipped.
- `O_frame_cnt`, out, 16: count of committed frames, wraps.

## Operation
- Edge detect: `vs_d` is `I_vs` registered; `vs_rise = I_vs & ~vs_d`.
- `IDLE`: `O_acc_en=0`. On `vs_rise`, pulse `O_acc_clr` and go to `ACTIVE`.
- `ACTIVE`: `O_acc_en=1`. On `vs_rise`, set `idx=0`, drive `O_acc_en=0` and go to `COPY`.
- `COPY`: each cycle, `shadow[idx]` takes the new value and `idx` increments.
  - When `idx==ZONES-1`, pulse `O_acc_clr`, increment `O_frame_cnt`, set `O_upd_req=1` and go to `HANDOFF`.
  - `vs_rise` during `COPY` is ignored.
- `HANDOFF`: `O_acc_en=1`, and `O_zone_data` holds constant.
  - On a cycle with `O_upd_req & I_upd_ack`, clear `O_upd_req` and go to `ACTIVE`.
  - On `vs_rise` with no ack in the same cycle, pulse `O_drop` and `O_acc_clr`, and stay in `HANDOFF` with the previous buffer.
  - On `vs_rise` and ack in the same cycle, the ack wins and the next state is `COPY` directly.
- Loss detection:
  - A 22-bit counter clears on every `vs_rise` and saturates.
  - When it reaches `TIMEOUT_CYC`, from any state except `HANDOFF`, set `O_video_lost=1` and enter `COPY` with source `FALLBACK` for all zones.
  - After that `HANDOFF` completes, go to `IDLE` instead of `ACTIVE`.
  - In `HANDOFF`, a timeout is deferred until the ack.
  - `O_video_lost` clears on the next `vs_rise`.
- `shadow` is `O_zone_data` directly. It is written only in `COPY`.
- The copy source index is the `idx` mux on `I_zone_data`. `idx` is 9 bits and never exceeds `ZONES-1`.

## Timing
- Reset values:
  - State `IDLE`, `idx=0`.
  - `O_acc_en=0`, `O_acc_clr=0`, `O_upd_req=0`, `O_drop=0`, `O_video_lost=0`, `O_frame_cnt=0`.
  - `O_zone_data` all zero, `vs_d=0`.
  - The loss counter resets to 0.
- `vs_rise` is seen in cycle N. The `COPY` entry registers in cycle N+1, and `O_acc_en` falls at N+1.
- Zone k is written at cycle N+1+k.
- `O_upd_req` rises and `O_acc_clr` pulses at cycle N+ZONES+1, and `O_acc_en` returns high there.
- Copy duration is exactly `ZONES` cycles. The vertical blanking interval must exceed `ZONES+2` cycles.
- Handshake rules:
  - `O_upd_req` is held until the cycle where `I_upd_ack=1`, and falls on the next edge.
  - `O_zone_data` does not change while `O_upd_req=1`.
  - `I_upd_ack` while `O_upd_req=0` is ignored.
- Reset asserted mid-`COPY` or mid-`HANDOFF` returns everything to reset values at the next edge. No partial frame is committed.

## Configuration
- `LED_IIR_EN` defined: each copied zone is computed as `new = (3*old + in + 2) >> 2` using a 10-bit intermediate; the result always fits `DW`.
  - The first commit after reset or after video loss loads `in` directly; this is tracked by a `primed` flag.
  - `FALLBACK` is always loaded directly.
- `LED_IIR_EN` undefined: `new = in`, and the `primed` logic is absent.

## Test plan
- Frame commit: pulse `I_vs` at 0, then 10k cycles later, with all zones 8'h80 and ack 5 cycles after req.
  - `O_acc_clr` pulses after the first edge.
  - `O_upd_req` rises 361 cycles after the second `vs_rise`.
  - `O_zone_data` is all 8'h80 and `O_frame_cnt=1`.
- Zone ordering: set zone k to `k[7:0]`.
  - After commit, `O_zone_data[k*8+:8]==k[7:0]` for all 360 zones, and writes land at cycles N+1+k.
- Stalled driver: hold `I_upd_ack=0` across two further `vs_rise` edges.
  - Two `O_drop` pulses, `O_zone_data` unchanged, `O_frame_cnt` unchanged.
- Simultaneous `vs_rise` and ack in `HANDOFF`: the next state is `COPY` and there is no `O_drop`.
- Video loss: stop `I_vs` for `TIMEOUT_CYC` cycles.
  - `O_video_lost=1`, all zones become 8'h40, and the FSM reaches `IDLE` after ack.
  - A new `vs_rise` clears the flag.
- IIR (`LED_IIR_EN`): first frame all 8'hFF, second frame all 8'h00.
  - The first commit gives 8'hFF; the second gives `(765+0+2)>>2 = 8'hBF`.

Source files
------------

// File: rtl/led_frame_sequencer.sv
// Per-frame zone snapshot, driver handoff and video-loss fallback for the MiniLED path.
// Optional macro LED_IIR_EN: temporal IIR smoothing of copied zones.
module led_frame_sequencer #(
  parameter int          ZONES       = 360,
  parameter int          DW          = 8,
  parameter int          TIMEOUT_CYC = 2_000_000,
  parameter logic [DW-1:0] FALLBACK  = 'h40
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_vs,
  input  logic [ZONES*DW-1:0] I_zone_data,
  output logic                O_acc_en,
  output logic                O_acc_clr,
  output logic [ZONES*DW-1:0] O_zone_data,
  output logic                O_upd_req,
  input  logic                I_upd_ack,
  output logic                O_video_lost,
  output logic                O_drop,
  output logic [15:0]         O_frame_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, COPY, HANDOFF} state_e;

  localparam logic [8:0]  LAST = 9'(ZONES - 1);
  localparam logic [21:0] TO   = 22'(TIMEOUT_CYC);

  state_e        state_q, state_d;
  logic [8:0]    idx_q, idx_d;
  logic [21:0]   cnt_q, cnt_d;
  logic          vs_q;
  logic          acc_en_q, acc_en_d;
  logic          acc_clr_q, acc_clr_d;
  logic          upd_req_q, upd_req_d;
  logic          drop_q, drop_d;
  logic          lost_q, lost_d;
  logic          fb_q, fb_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [DW-1:0] shadow_q [ZONES];
  logic [DW-1:0] shadow_d [ZONES];
  logic [DW-1:0] zin [ZONES];
  logic [DW-1:0] nv;
  logic          vs_rise;
  logic          to_hit;
  logic          ack;

  for (genvar k = 0; k < ZONES; k++) begin : g_zone
    assign zin[k]                  = I_zone_data[k*DW +: DW];
    assign O_zone_data[k*DW +: DW] = shadow_q[k];
  end

  assign vs_rise = I_vs & ~vs_q;
  // One-shot: the counter stays saturated until vsync returns.
  assign to_hit  = (cnt_q == TO) & ~vs_rise & ~lost_q;
  assign ack     = upd_req_q & I_upd_ack;
  assign cnt_d   = vs_rise ? '0 : (cnt_q == TO) ? cnt_q : cnt_q + 22'd1;

`ifdef LED_IIR_EN
  logic          primed_q, primed_d;
  logic [DW+1:0] old_w, in_w, mix;

  assign old_w = {2'b00, shadow_q[idx_q]};
  assign in_w  = {2'b00, zin[idx_q]};
  assign mix   = (old_w << 1) + old_w + in_w + (DW+2)'(2);

  always_comb begin
    nv = zin[idx_q];
    if (fb_q)          nv = FALLBACK;
    else if (primed_q) nv = mix[DW+1:2];
  end
`else
  assign nv = fb_q ? FALLBACK : zin[idx_q];
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_en_d    = acc_en_q;
    acc_clr_d   = 1'b0;
    upd_req_d   = upd_req_q;
    drop_d      = 1'b0;
    lost_d      = lost_q & ~vs_rise;
    fb_d        = fb_q;
    frame_cnt_d = frame_cnt_q;
    shadow_d    = shadow_q;
`ifdef LED_IIR_EN
    primed_d    = primed_q;
`endif
    unique case (state_q)
      IDLE: begin
        acc_en_d = 1'b0;
        if (vs_rise) begin
          acc_clr_d = 1'b1;
          acc_en_d  = 1'b1;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          state_d  = COPY;
          idx_d    = '0;
          acc_en_d = 1'b0;
        end
      end
      COPY: begin
        shadow_d[idx_q] = nv;
        if (idx_q == LAST) begin
          acc_clr_d   = 1'b1;
          acc_en_d    = 1'b1;
          upd_req_d   = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = HANDOFF;
`ifdef LED_IIR_EN
          primed_d    = ~fb_q;
`endif
        end else begin
          idx_d = idx_q + 9'd1;
        end
      end
      HANDOFF: begin
        if (ack) begin
          upd_req_d = 1'b0;
          fb_d      = 1'b0;
          if (vs_rise || to_hit) begin
            state_d  = COPY;
            idx_d    = '0;
            acc_en_d = 1'b0;
          end else if (fb_q) begin
            state_d  = IDLE;
            acc_en_d = 1'b0;
          end else begin
            state_d = ACTIVE;
          end
        end else if (vs_rise) begin
          drop_d    = 1'b1;
          acc_clr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Loss overrides everything but an un-acked handoff.
    if (to_hit && (state_q != HANDOFF || ack)) begin
      state_d  = COPY;
      idx_d    = '0;
      acc_en_d = 1'b0;
      fb_d     = 1'b1;
      lost_d   = 1'b1;
`ifdef LED_IIR_EN
      primed_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      vs_q        <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_clr_q   <= 1'b0;
      upd_req_q   <= 1'b0;
      drop_q      <= 1'b0;
      lost_q      <= 1'b0;
      fb_q        <= 1'b0;
      frame_cnt_q <= '0;
      for (int k = 0; k < ZONES; k++) shadow_q[k] <= '0;
`ifdef LED_IIR_EN
      primed_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      vs_q        <= I_vs;
      acc_en_q    <= acc_en_d;
      acc_clr_q   <= acc_clr_d;
      upd_req_q   <= upd_req_d;
      drop_q      <= drop_d;
      lost_q      <= lost_d;
      fb_q        <= fb_d;
      frame_cnt_q <= frame_cnt_d;
      shadow_q    <= shadow_d;
`ifdef LED_IIR_EN
      primed_q    <= primed_d;
`endif
    end
  end

  assign O_acc_en     = acc_en_q;
  assign O_acc_clr    = acc_clr_q;
  assign O_upd_req    = upd_req_q;
  assign O_drop       = drop_q;
  assign O_video_lost = lost_q;
  assign O_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench for led_frame_sequencer: commit, ordering, stall, ack race, loss, reset.
// Expected zone values track LED_IIR_EN through a small reference model.
module tb_led_frame_sequencer;

  localparam int ZONES = 360;
  localparam int TO    = 3000;

  logic                I_clk = 1'b0;
  logic                I_rst_n = 1'b0;
  logic                I_vs = 1'b0;
  logic                I_upd_ack = 1'b0;
  logic [ZONES*8-1:0]  I_zone_data;
  logic                O_acc_en, O_acc_clr, O_upd_req;
  logic                O_video_lost, O_drop;
  logic [ZONES*8-1:0]  O_zone_data;
  logic [15:0]         O_frame_cnt;

  logic [7:0] pat   [ZONES];
  logic [7:0] exp_z [ZONES];
  bit         primed = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 I_clk = ~I_clk;

  always_comb begin
    I_zone_data = '0;
    for (int k = 0; k < ZONES; k++) I_zone_data[k*8 +: 8] = pat[k];
  end

  led_frame_sequencer #(.ZONES(ZONES), .DW(8), .TIMEOUT_CYC(TO), .FALLBACK(8'h40)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_vs(I_vs),
    .I_zone_data(I_zone_data), .O_acc_en(O_acc_en), .O_acc_clr(O_acc_clr),
    .O_zone_data(O_zone_data), .O_upd_req(O_upd_req), .I_upd_ack(I_upd_ack),
    .O_video_lost(O_video_lost), .O_drop(O_drop), .O_frame_cnt(O_frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] zone(input int i);
    return O_zone_data[i*8 +: 8];
  endfunction

  function automatic logic [7:0] nxt(input logic [7:0] old, input logic [7:0] in);
`ifdef LED_IIR_EN
    int s;
    s = 3 * int'(old) + int'(in) + 2;
    return primed ? 8'(s >> 2) : in;
`else
    return in;
`endif
  endfunction

  function automatic int zone_errs();
    int e = 0;
    for (int k = 0; k < ZONES; k++) if (zone(k) !== exp_z[k]) e++;
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge I_clk);
  endtask

  task automatic run_frame(input int probe, input bit with_ack, input int cnt);
    logic [7:0] nz [ZONES];
    int n;
    for (int k = 0; k < ZONES; k++) nz[k] = nxt(exp_z[k], pat[k]);
    I_vs = 1'b1;
    I_upd_ack = with_ack;
    n = 0;
    do begin
      @(negedge I_clk);
      n++;
      I_vs = 1'b0;
      I_upd_ack = 1'b0;
      if (n == 1) begin
        check("acc_en_fall", O_acc_en, 0);
        if (with_ack) check("race_no_drop", O_drop, 0);
      end
      if (n == probe) begin
        check("wr_landed", zone(probe-2), nz[probe-2]);
        check("wr_pending", zone(probe-1), exp_z[probe-1]);
      end
    end while (!O_upd_req && n < 1000);
    check("req_latency", n, 361);
    check("clr_at_req", O_acc_clr, 1);
    check("acc_en_back", O_acc_en, 1);
    exp_z = nz;
    primed = 1'b1;
    check("zones", zone_errs(), 0);
    check("frame_cnt", O_frame_cnt, cnt);
  endtask

  task automatic ack_req();
    idle(4);
    I_upd_ack = 1'b1;
    @(negedge I_clk);
    I_upd_ack = 1'b0;
    check("req_drop", O_upd_req, 0);
  endtask

  initial begin
    int n, drops;
    for (int k = 0; k < ZONES; k++) begin
      pat[k] = 8'h80;
      exp_z[k] = 8'h00;
    end
    idle(3);
    check("rst_acc_en", O_acc_en, 0);
    check("rst_acc_clr", O_acc_clr, 0);
    check("rst_req", O_upd_req, 0);
    check("rst_lost", O_video_lost, 0);
    check("rst_cnt", O_frame_cnt, 0);
    check("rst_zones", zone_errs(), 0);
    I_rst_n = 1'b1;
    idle(2);

    I_vs = 1'b1;
    @(negedge I_clk);
    I_vs = 1'b0;
    check("first_clr", O_acc_clr, 1);
    check("first_en", O_acc_en, 1);
    idle(1);
    check("clr_one_cycle", O_acc_clr, 0);
    idle(1000);

    run_frame(3, 1'b0, 1);
    ack_req();
    idle(500);

    for (int k = 0; k < ZONES; k++) pat[k] = 8'(k);
    run_frame(101, 1'b0, 2);
    ack_req();
    idle(500);

    for (int k = 0; k < ZONES; k++) pat[k] = 8'(k + 1);
    run_frame(50, 1'b0, 3);
    for (int k = 0; k < ZONES; k++) pat[k] = 8'h11;
    drops = 0;
    for (int p = 0; p < 2; p++) begin
      I_vs = 1'b1;
      repeat (300) begin
        @(negedge I_clk);
        I_vs = 1'b0;
        if (O_drop) drops++;
      end
    end
    check("stall_drops", drops, 2);
    check("stall_zones", zone_errs(), 0);
    check("stall_cnt", O_frame_cnt, 3);
    check("stall_req", O_upd_req, 1);

    run_frame(200, 1'b1, 4);
    ack_req();

    n = 0;
    while (!O_video_lost && n < 5000) begin
      @(negedge I_clk);
      n++;
    end
    check("lost_set", O_video_lost, 1);
    n = 0;
    while (!O_upd_req && n < 1000) begin
      @(negedge I_clk);
      n++;
    end
    for (int k = 0; k < ZONES; k++) exp_z[k] = 8'h40;
    primed = 1'b0;
    check("fb_zones", zone_errs(), 0);
    check("fb_cnt", O_frame_cnt, 5);
    ack_req();
    check("idle_after_fb", O_acc_en, 0);
    idle(20);
    check("idle_stays", O_acc_en, 0);
    check("no_refire", O_upd_req, 0);
    I_vs = 1'b1;
    @(negedge I_clk);
    I_vs = 1'b0;
    check("lost_clear", O_video_lost, 0);
    check("resume_clr", O_acc_clr, 1);
    check("resume_en", O_acc_en, 1);
    idle(100);

    I_vs = 1'b1;
    @(negedge I_clk);
    I_vs = 1'b0;
    idle(50);
    I_rst_n = 1'b0;
    @(negedge I_clk);
    for (int k = 0; k < ZONES; k++) exp_z[k] = 8'h00;
    check("midrst_zones", zone_errs(), 0);
    check("midrst_cnt", O_frame_cnt, 0);
    check("midrst_en", O_acc_en, 0);
    check("midrst_req", O_upd_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
